tdc_multi_channel_ctrl: RTL and testbench

TDC_MULTI_CHANNEL_CTRL -- requirements
Module: tdc_multi_channel_ctrl

---
 rtl/tdc_pkg.sv | 51 +++++
 rtl/tdc_channel_fsm.sv | 141 ++++++++++++++
 rtl/tdc_multi_channel_ctrl.sv | 146 ++++++++++++++
 tb/tb_tdc_multi_channel_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// Shared types and constants for the multi-channel TDC controller.
// Holds the per-channel state encoding, the edge-mode encodings and the
// widths that make up one result record (channel, coarse, fine start/stop).
package tdc_pkg;

  // Per-channel measurement state.
  typedef enum logic [2:0] {
    CH_IDLE      = 3'd0,
    CH_ARMED     = 3'd1,
    CH_MEASURING = 3'd2,
    CH_DONE      = 3'd3,
    CH_ERROR     = 3'd4
  } ch_state_e;

  // Edge-mode encodings, two bits per channel.
  localparam logic [1:0] EDGE_RISE     = 2'b00;
  localparam logic [1:0] EDGE_FALL     = 2'b01;
  localparam logic [1:0] EDGE_BOTH     = 2'b10;
  localparam logic [1:0] EDGE_RISE_ALT = 2'b11;  // reserved code, behaves as rising

  // Width of the per-channel delivered-result counter.
  localparam int HIT_CNT_W = 16;

  // Channel-index width of a result record; never narrower than one bit.
  function automatic int ch_idx_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  // Total width of one result record: channel + coarse + fine start + fine stop.
  function automatic int result_w(input int num_ch, input int coarse_w, input int fine_w);
    return ch_idx_w(num_ch) + coarse_w + 2 * fine_w;
  endfunction

  // Edge qualifier for one level given its previous-cycle sample.
  function automatic logic edge_hit(input logic [1:0] mode, input logic cur, input logic prev);
    logic rise;
    logic fall;
    logic hit;
    rise = cur & ~prev;
    fall = ~cur & prev;
    hit  = rise;
    case (mode)
      EDGE_RISE:     hit = rise;
      EDGE_FALL:     hit = fall;
      EDGE_BOTH:     hit = rise | fall;
      EDGE_RISE_ALT: hit = rise;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/tdc_channel_fsm.sv
// One TDC channel: START/STOP edge detection, measurement FSM, coarse
// cycle counter and capture of the fine tap positions.
// The state register is exported so the parent decodes status from it.
module tdc_channel_fsm
  import tdc_pkg::*;
#(
  parameter int COARSE_W       = 16,
  parameter int FINE_W         = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic              sys_clk_p,
  input  logic              sys_rst,
  input  logic              tdc_enable,
  input  logic              tdc_arm,
  input  logic [1:0]        edge_mode,
  input  logic              tdc_start,
  input  logic              tdc_stop,
  input  logic [FINE_W-1:0] fine_start,
  input  logic [FINE_W-1:0] fine_stop,
  input  logic              grant,
  output ch_state_e         state,
  output logic [COARSE_W-1:0] res_coarse,
  output logic [FINE_W-1:0] res_fine_start,
  output logic [FINE_W-1:0] res_fine_stop
);

  // The running counter must reach TIMEOUT_CYCLES even when the reported
  // coarse field is narrower, so it is sized for whichever is larger.
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W = (TO_W > COARSE_W) ? TO_W : COARSE_W;
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

  ch_state_e        state_next;
  logic             start_prev;
  logic             stop_prev;
  logic             hist_valid;
  logic             start_edge;
  logic             stop_edge;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_plus1;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             cap_start;
  logic             cap_stop;
  logic             cap_coarse_zero;
  logic             cap_coarse_cnt;

  // Edge history; hist_valid masks the first cycle after reset.
  always_ff @(posedge sys_clk_p) begin
    if (sys_rst) begin
      start_prev <= 1'b0;
      stop_prev  <= 1'b0;
      hist_valid <= 1'b0;
    end else begin
      start_prev <= tdc_start;
      stop_prev  <= tdc_stop;
      hist_valid <= 1'b1;
    end
  end

  assign start_edge = hist_valid & edge_hit(edge_mode, tdc_start, start_prev);
  assign stop_edge  = hist_valid & edge_hit(edge_mode, tdc_stop, stop_prev);

  // cnt counts MEASURING cycles after the start-edge cycle, so the stop-edge
  // cycle itself is cnt+1 cycles after the start edge.
  assign cnt_plus1 = cnt + 1'b1;

  // State register.
  always_ff @(posedge sys_clk_p) begin
    if (sys_rst) state <= CH_IDLE;
    else         state <= state_next;
  end

  // Next-state and datapath strobes; disabling the block wins over everything.
  always_comb begin
    state_next      = state;
    cnt_clr         = 1'b0;
    cnt_inc         = 1'b0;
    cap_start       = 1'b0;
    cap_stop        = 1'b0;
    cap_coarse_zero = 1'b0;
    cap_coarse_cnt  = 1'b0;
    if (!tdc_enable) begin
      state_next = CH_IDLE;
    end else begin
      case (state)
        CH_IDLE: begin
          if (tdc_arm) state_next = CH_ARMED;
        end
        CH_ARMED: begin
          if (start_edge && stop_edge) begin
            state_next      = CH_DONE;
            cap_start       = 1'b1;
            cap_stop        = 1'b1;
            cap_coarse_zero = 1'b1;
          end else if (start_edge) begin
            state_next = CH_MEASURING;
            cnt_clr    = 1'b1;
            cap_start  = 1'b1;
          end
        end
        CH_MEASURING: begin
          if (stop_edge) begin
            state_next     = CH_DONE;
            cap_stop       = 1'b1;
            cap_coarse_cnt = 1'b1;
          end else if (cnt_plus1 == TIMEOUT_VAL) begin
            state_next = CH_ERROR;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        CH_DONE: begin
          if (grant) state_next = CH_IDLE;
        end
        CH_ERROR: begin
          state_next = CH_ERROR;
        end
        default: state_next = CH_IDLE;
      endcase
    end
  end

  // Coarse counter and captured results.
  always_ff @(posedge sys_clk_p) begin
    if (sys_rst) begin
      cnt            <= '0;
      res_coarse     <= '0;
      res_fine_start <= '0;
      res_fine_stop  <= '0;
    end else begin
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt_plus1;
      if (cap_start) res_fine_start <= fine_start;
      if (cap_stop)  res_fine_stop  <= fine_stop;
      if (cap_coarse_zero)     res_coarse <= '0;
      else if (cap_coarse_cnt) res_coarse <= cnt_plus1[COARSE_W-1:0];
    end
  end

endmodule

// File: rtl/tdc_multi_channel_ctrl.sv
// Multi-channel TDC controller: NUM_CH independent start/stop channels,
// a round-robin arbiter over finished channels and one registered result
// stream. Optional feature macro: TDC_HIT_COUNT_EN adds per-channel
// saturating counts of delivered results on output hit_count.
module tdc_multi_channel_ctrl
  import tdc_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int COARSE_W       = 16,
  parameter int FINE_W         = 8,
  parameter int TIMEOUT_CYCLES = 100000,
  localparam int CH_W          = ch_idx_w(NUM_CH)
) (
  input  logic                     sys_clk_p,
  input  logic                     sys_rst,
  input  logic                     tdc_enable,
  input  logic [NUM_CH-1:0]        tdc_arm,
  input  logic [2*NUM_CH-1:0]      edge_mode,
  input  logic [NUM_CH-1:0]        tdc_start,
  input  logic [NUM_CH-1:0]        tdc_stop,
  input  logic [NUM_CH*FINE_W-1:0] fine_start,
  input  logic [NUM_CH*FINE_W-1:0] fine_stop,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [CH_W-1:0]          m_channel,
  output logic [COARSE_W-1:0]      m_coarse,
  output logic [FINE_W-1:0]        m_fine_start,
  output logic [FINE_W-1:0]        m_fine_stop,
  output logic [NUM_CH-1:0]        ch_armed,
  output logic [NUM_CH-1:0]        ch_measuring,
  output logic [NUM_CH-1:0]        ch_error,
`ifdef TDC_HIT_COUNT_EN
  output logic [NUM_CH*HIT_CNT_W-1:0] hit_count,
`endif
  output logic                     tdc_ready
);

  // Result stream handshake: a word transfers on a rising sys_clk_p edge
  // where m_valid && m_ready. Once m_valid is high the m_* fields hold until
  // that transfer; a new word may load in the same cycle as the transfer.

  ch_state_e            ch_state       [NUM_CH];
  logic [COARSE_W-1:0]  ch_coarse      [NUM_CH];
  logic [FINE_W-1:0]    ch_fine_start  [NUM_CH];
  logic [FINE_W-1:0]    ch_fine_stop   [NUM_CH];
  logic [NUM_CH-1:0]    ch_done;
  logic [NUM_CH-1:0]    grant;
  logic                 grant_any;
  logic [CH_W-1:0]      grant_idx;
  logic [CH_W-1:0]      rr_ptr;
  logic [CH_W-1:0]      scan_idx;
  logic [CH_W:0]        scan_sum;
  logic                 load_ok;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tdc_channel_fsm #(
      .COARSE_W       (COARSE_W),
      .FINE_W         (FINE_W),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_ch (
      .sys_clk_p      (sys_clk_p),
      .sys_rst        (sys_rst),
      .tdc_enable     (tdc_enable),
      .tdc_arm        (tdc_arm[i]),
      .edge_mode      (edge_mode[2*i +: 2]),
      .tdc_start      (tdc_start[i]),
      .tdc_stop       (tdc_stop[i]),
      .fine_start     (fine_start[i*FINE_W +: FINE_W]),
      .fine_stop      (fine_stop[i*FINE_W +: FINE_W]),
      .grant          (grant[i]),
      .state          (ch_state[i]),
      .res_coarse     (ch_coarse[i]),
      .res_fine_start (ch_fine_start[i]),
      .res_fine_stop  (ch_fine_stop[i])
    );

    assign ch_armed[i]     = (ch_state[i] == CH_ARMED);
    assign ch_measuring[i] = (ch_state[i] == CH_MEASURING);
    assign ch_error[i]     = (ch_state[i] == CH_ERROR);
    assign ch_done[i]      = (ch_state[i] == CH_DONE);
  end

  assign tdc_ready = tdc_enable && !(|ch_error);
  assign load_ok   = !m_valid || m_ready;

  // Round-robin pick: scan from rr_ptr, which sits just after the last grant.
  // No grant while disabled, so pending DONE results are dropped.
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    if (tdc_enable && load_ok) begin
      for (int k = 0; k < NUM_CH; k++) begin
        scan_sum = {1'b0, rr_ptr} + (CH_W+1)'(k);
        if (scan_sum >= (CH_W+1)'(NUM_CH)) scan_sum = scan_sum - (CH_W+1)'(NUM_CH);
        scan_idx = scan_sum[CH_W-1:0];
        if (!grant_any && ch_done[scan_idx]) begin
          grant_any = 1'b1;
          grant_idx = scan_idx;
        end
      end
      if (grant_any) grant[grant_idx] = 1'b1;
    end
  end

  // Output register and arbiter pointer.
  always_ff @(posedge sys_clk_p) begin
    if (sys_rst) begin
      rr_ptr       <= '0;
      m_valid      <= 1'b0;
      m_channel    <= '0;
      m_coarse     <= '0;
      m_fine_start <= '0;
      m_fine_stop  <= '0;
    end else if (grant_any) begin
      rr_ptr       <= (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
      m_valid      <= 1'b1;
      m_channel    <= grant_idx;
      m_coarse     <= ch_coarse[grant_idx];
      m_fine_start <= ch_fine_start[grant_idx];
      m_fine_stop  <= ch_fine_stop[grant_idx];
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

`ifdef TDC_HIT_COUNT_EN
  logic [HIT_CNT_W-1:0] hit_cnt [NUM_CH];

  // Saturating count of words actually delivered, per source channel.
  always_ff @(posedge sys_clk_p) begin
    if (sys_rst) begin
      for (int i = 0; i < NUM_CH; i++) hit_cnt[i] <= '0;
    end else if (m_valid && m_ready && (hit_cnt[m_channel] != '1)) begin
      hit_cnt[m_channel] <= hit_cnt[m_channel] + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_hit
    assign hit_count[i*HIT_CNT_W +: HIT_CNT_W] = hit_cnt[i];
  end
`endif

endmodule

// File: tb/tb_tdc_multi_channel_ctrl.sv
// Directed bench for tdc_multi_channel_ctrl (NUM_CH=4, TIMEOUT_CYCLES=1000).
// Inputs change 1 time unit after a rising edge and outputs are sampled at
// the same point; delivered words are checked against an expected queue.
module tb_tdc_multi_channel_ctrl;

  localparam int NUM_CH         = 4;
  localparam int COARSE_W       = 16;
  localparam int FINE_W         = 8;
  localparam int TIMEOUT_CYCLES = 1000;
  localparam int CH_W           = 2;
  localparam int W              = CH_W + COARSE_W + 2 * FINE_W;

  logic                     sys_clk_p;
  logic                     sys_rst;
  logic                     tdc_enable;
  logic [NUM_CH-1:0]        tdc_arm;
  logic [2*NUM_CH-1:0]      edge_mode;
  logic [NUM_CH-1:0]        tdc_start;
  logic [NUM_CH-1:0]        tdc_stop;
  logic [NUM_CH*FINE_W-1:0] fine_start;
  logic [NUM_CH*FINE_W-1:0] fine_stop;
  logic                     m_valid;
  logic                     m_ready;
  logic [CH_W-1:0]          m_channel;
  logic [COARSE_W-1:0]      m_coarse;
  logic [FINE_W-1:0]        m_fine_start;
  logic [FINE_W-1:0]        m_fine_stop;
  logic [NUM_CH-1:0]        ch_armed;
  logic [NUM_CH-1:0]        ch_measuring;
  logic [NUM_CH-1:0]        ch_error;
  logic                     tdc_ready;
`ifdef TDC_HIT_COUNT_EN
  logic [NUM_CH*16-1:0]     hit_count;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];

  tdc_multi_channel_ctrl #(
    .NUM_CH         (NUM_CH),
    .COARSE_W       (COARSE_W),
    .FINE_W         (FINE_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .sys_clk_p    (sys_clk_p),
    .sys_rst      (sys_rst),
    .tdc_enable   (tdc_enable),
    .tdc_arm      (tdc_arm),
    .edge_mode    (edge_mode),
    .tdc_start    (tdc_start),
    .tdc_stop     (tdc_stop),
    .fine_start   (fine_start),
    .fine_stop    (fine_stop),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_channel    (m_channel),
    .m_coarse     (m_coarse),
    .m_fine_start (m_fine_start),
    .m_fine_stop  (m_fine_stop),
    .ch_armed     (ch_armed),
    .ch_measuring (ch_measuring),
    .ch_error     (ch_error),
`ifdef TDC_HIT_COUNT_EN
    .hit_count    (hit_count),
`endif
    .tdc_ready    (tdc_ready)
  );

  // Clock and reset
  initial sys_clk_p = 1'b0;
  always #5 sys_clk_p = ~sys_clk_p;

  // Driver tasks
  task automatic tick();
    @(posedge sys_clk_p);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
  endtask

  task automatic set_fine(input int ch, input logic [FINE_W-1:0] fs, input logic [FINE_W-1:0] fst);
    fine_start[ch*FINE_W +: FINE_W] = fs;
    fine_stop[ch*FINE_W +: FINE_W]  = fst;
  endtask

  task automatic arm_ch(input int ch);
    tdc_arm[ch] = 1'b1;
    tick();
    tdc_arm[ch] = 1'b0;
  endtask

  task automatic push_exp(input int ch, input int coarse, input logic [FINE_W-1:0] fs,
                          input logic [FINE_W-1:0] fst);
    exp_q.push_back({CH_W'(ch), COARSE_W'(coarse), fs, fst});
  endtask

  // Scoreboard: every delivered word must be the next expected one.
  always @(negedge sys_clk_p) begin
    if (!sys_rst && m_valid && m_ready) begin
      check("word_expected", {63'd0, exp_q.size() != 0}, 64'd1);
      if (exp_q.size() != 0)
        check("word", 64'({m_channel, m_coarse, m_fine_start, m_fine_stop}), 64'(exp_q.pop_front()));
    end
  end

  initial begin
    sys_rst    = 1'b1;
    tdc_enable = 1'b0;
    tdc_arm    = '0;
    edge_mode  = '0;
    tdc_start  = '0;
    tdc_stop   = '0;
    fine_start = '0;
    fine_stop  = '0;
    m_ready    = 1'b1;

    // Reset state
    repeat (2) tick();
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_coarse", 64'(m_coarse), 64'd0);
    check("rst_status", 64'({ch_armed, ch_measuring, ch_error}), 64'd0);
    check("rst_ready_disabled", 64'(tdc_ready), 64'd0);
    sys_rst    = 1'b0;
    tdc_enable = 1'b1;
    tick();
    check("ready_enabled", 64'(tdc_ready), 64'd1);

    // ch0 rising: stop alone ignored while armed, then 25-cycle measurement
    arm_ch(0);
    check("a_armed", 64'(ch_armed), 64'h1);
    tdc_stop[0] = 1'b1;
    tick();
    check("a_stop_alone_ignored", 64'(ch_armed), 64'h1);
    tdc_stop[0] = 1'b0;
    tick();
    set_fine(0, 8'd37, 8'd0);
    tdc_start[0] = 1'b1;
    tick();
    check("a_measuring", 64'(ch_measuring), 64'h1);
    repeat (24) tick();
    set_fine(0, 8'd0, 8'd200);
    tdc_stop[0] = 1'b1;
    push_exp(0, 25, 8'd37, 8'd200);
    tick();
    check("a_latency_no_valid_yet", 64'(m_valid), 64'd0);
    check("a_left_measuring", 64'(ch_measuring), 64'd0);
    tick();
    check("a_m_valid", 64'(m_valid), 64'd1);
    check("a_m_coarse", 64'(m_coarse), 64'd25);
    check("a_m_fine_start", 64'(m_fine_start), 64'd37);
    check("a_m_fine_stop", 64'(m_fine_stop), 64'd200);
    tdc_start = '0;
    tdc_stop  = '0;
    tick();

    // ch1 falling: start and stop fall together -> coarse 0, single result
    edge_mode[3:2] = 2'b01;
    tdc_start[1] = 1'b1;
    tdc_stop[1]  = 1'b1;
    tick();
    arm_ch(1);
    set_fine(1, 8'd5, 8'd9);
    tdc_start[1] = 1'b0;
    tdc_stop[1]  = 1'b0;
    push_exp(1, 0, 8'd5, 8'd9);
    tick();
    check("b_done_not_armed", 64'({ch_armed, ch_measuring}), 64'd0);
    tick();
    check("b_m_valid", 64'(m_valid), 64'd1);
    check("b_m_channel", 64'(m_channel), 64'd1);
    check("b_m_coarse", 64'(m_coarse), 64'd0);
    tick();
    check("b_single_result", 64'(m_valid), 64'd0);
    edge_mode = '0;

    // Reset in the middle of a measurement discards everything
    arm_ch(2);
    tdc_start[2] = 1'b1;
    tick();
    check("d_measuring", 64'(ch_measuring), 64'h4);
    repeat (3) tick();
    sys_rst   = 1'b1;
    tdc_start = '0;
    tick();
    check("d_rst_m_valid", 64'(m_valid), 64'd0);
    check("d_rst_m_fields", 64'({m_channel, m_coarse, m_fine_start, m_fine_stop}), 64'd0);
    check("d_rst_status", 64'({ch_armed, ch_measuring, ch_error}), 64'd0);
    sys_rst = 1'b0;
    tick();
    check("d_ready_after_rst", 64'(tdc_ready), 64'd1);
    check("d_no_word", 64'(m_valid), 64'd0);

    // All four channels finish together; arbiter pointer is 0 after reset
    m_ready = 1'b0;
    tdc_arm = 4'hf;
    tick();
    tdc_arm = '0;
    check("c_all_armed", 64'(ch_armed), 64'hf);
    for (int i = 0; i < NUM_CH; i++) begin
      set_fine(i, FINE_W'(10 + i), FINE_W'(20 + i));
      push_exp(i, 0, FINE_W'(10 + i), FINE_W'(20 + i));
    end
    tdc_start = 4'hf;
    tdc_stop  = 4'hf;
    tick();
    check("c_all_done", 64'(ch_armed), 64'd0);
    tick();
    for (int j = 0; j < 5; j++) begin
      check("c_hold_valid", 64'(m_valid), 64'd1);
      check("c_hold_word", 64'({m_channel, m_coarse, m_fine_start, m_fine_stop}),
            64'({2'd0, 16'd0, 8'd10, 8'd20}));
      tick();
    end
    m_ready = 1'b1;
    tick();
    check("c_second_ch1", 64'(m_channel), 64'd1);
    tick();
    check("c_third_ch2", 64'(m_channel), 64'd2);
    tick();
    check("c_fourth_ch3", 64'(m_channel), 64'd3);
    tick();
    check("c_drained", 64'(m_valid), 64'd0);
    tdc_start = '0;
    tdc_stop  = '0;
    tick();

    // ch2 timeout -> sticky error; cleared by one cycle of tdc_enable low
    arm_ch(2);
    tdc_start[2] = 1'b1;
    tick();
    repeat (999) tick();
    check("e_still_measuring", 64'(ch_measuring), 64'h4);
    check("e_no_error_yet", 64'(ch_error), 64'd0);
    tick();
    check("e_error", 64'(ch_error), 64'h4);
    check("e_ready_low", 64'(tdc_ready), 64'd0);
    tdc_arm[2] = 1'b1;
    tick();
    tdc_arm[2] = 1'b0;
    check("e_error_sticky", 64'({ch_armed, ch_error}), 64'h4);
    tdc_enable = 1'b0;
    tick();
    check("e_error_cleared", 64'(ch_error), 64'd0);
    tdc_enable   = 1'b1;
    tdc_start[2] = 1'b0;
    tick();
    check("e_ready_back", 64'(tdc_ready), 64'd1);

    // Disable discards pending DONE but the registered word is still delivered
    m_ready = 1'b0;
    tdc_arm = 4'b0011;
    tick();
    tdc_arm = '0;
    set_fine(0, 8'd1, 8'd2);
    set_fine(1, 8'd3, 8'd4);
    push_exp(0, 0, 8'd1, 8'd2);
    tdc_start = 4'b0011;
    tdc_stop  = 4'b0011;
    tick();
    tick();
    check("f_word_ch0", 64'({m_valid, m_channel}), 64'({1'b1, 2'd0}));
    tdc_enable = 1'b0;
    tdc_arm    = 4'b0100;
    tick();
    tdc_arm = '0;
    check("f_arm_ignored_disabled", 64'(ch_armed), 64'd0);
    check("f_word_kept", 64'({m_valid, m_channel}), 64'({1'b1, 2'd0}));
    tdc_enable = 1'b1;
    m_ready    = 1'b1;
    tick();
    check("f_ch1_discarded", 64'(m_valid), 64'd0);
    tdc_start = '0;
    tdc_stop  = '0;
    tick();

`ifdef TDC_HIT_COUNT_EN
    // Delivered-result counter: three ch3 words after a fresh reset
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    tick();
    for (int r = 0; r < 3; r++) begin
      arm_ch(3);
      set_fine(3, FINE_W'(r), FINE_W'(r + 1));
      push_exp(3, 0, FINE_W'(r), FINE_W'(r + 1));
      tdc_start[3] = 1'b1;
      tdc_stop[3]  = 1'b1;
      tick();
      tick();
      tick();
      tdc_start = '0;
      tdc_stop  = '0;
      tick();
    end
    check("g_hit_count", 64'(hit_count), 64'({16'd3, 16'd0, 16'd0, 16'd0}));
`endif

    // Final report
    repeat (3) tick();
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
